pa_clic_int_src: RTL and testbench
==================================

PA_CLIC_INT_SRC -- requirements
Module: pa_clic_int_src

Interface
REQ-001 SHALL have parameter CNT_W, default 4, the width of the queued-event counter.
REQ-002 SHALL have input kid_sample_clk, 1 bit, the block clock; all state updates on its rising edge.
REQ-003 SHALL have input cpurst_b, 1 bit, the reset: asynchronous, active-low.
REQ-004 SHALL have input src_mode, 1 bit: 0 = level mode, 1 = pulse mode.
REQ-005 SHALL have input src_level, 1 bit, the peripheral level request, used in level mode.
REQ-006 SHALL have input src_event, 1 bit, a one-cycle peripheral event strobe, used in pulse mode.
REQ-007 SHALL have input cfg_high_cyc, 4 bits, the pulse-high width in cycles.
REQ-008 SHALL have input cfg_low_cyc, 4 bits, the minimum low gap in cycles.
REQ-009 SHALL have input src_ovf_clr, 1 bit, which clears the sticky overflow flag.
REQ-010 SHALL have output src_int_vld, 1 bit, registered, driving the CLIC kid interrupt-valid input.
REQ-011 SHALL have output src_evt_cnt, CNT_W bits, the number of queued events not yet emitted.
REQ-012 SHALL have output src_evt_ovf, 1 bit, a sticky flag: an event was dropped.
REQ-013 SHALL have output src_busy, 1 bit, high when the state machine is not IDLE or src_evt_cnt is nonzero.

Function
REQ-014 SHALL implement a state machine with states IDLE, HIGH and GAP; src_int_vld is 1 only in HIGH while in pulse mode.
REQ-015 Level mode SHALL drive src_int_vld from src_level registered once (1 cycle latency).
- In level mode the state machine SHALL be held in IDLE and the counter held at 0.
- In level mode src_event SHALL be ignored.
REQ-016 Pulse mode, each src_event SHALL increment src_evt_cnt.
- Increment and dequeue in the same cycle SHALL leave the count unchanged.
REQ-017 IDLE with src_evt_cnt nonzero SHALL move to HIGH on the next edge and decrement the count.
- Consequence: an event at edge E1 into an empty IDLE block gives src_evt_cnt=1 after E1 and src_int_vld=1 after E2.
REQ-018 HIGH SHALL last exactly max(cfg_high_cyc,1) cycles, then move to GAP.
REQ-019 GAP SHALL last exactly max(cfg_low_cyc,1) cycles.
- At expiry, if src_evt_cnt is nonzero: move to HIGH and decrement the count.
- At expiry, if src_evt_cnt is 0: move to IDLE.
REQ-020 cfg_high_cyc and cfg_low_cyc SHALL be sampled on entry to HIGH and GAP respectively; changes mid-phase SHALL NOT alter the current phase.
REQ-021 An event arriving when the counter is at its maximum, with no same-cycle dequeue, SHALL be dropped and SHALL set src_evt_ovf.
REQ-022 src_evt_ovf SHALL hold until src_ovf_clr; if set and clear coincide, set SHALL win.
REQ-023 A mode change from pulse to level SHALL abort on the next edge:
- state goes to IDLE and the counter to 0;
- src_int_vld follows src_level one cycle later;
- src_evt_ovf is preserved.
REQ-024 A mode change from level to pulse SHALL start in IDLE with src_int_vld=0 and an empty queue.

Reset
REQ-025 On cpurst_b low, all state SHALL reset asynchronously:
- state machine to IDLE;
- src_int_vld=0, src_evt_cnt=0, src_evt_ovf=0, src_busy=0;
- phase timers to 0.
REQ-026 Assertion mid-pulse SHALL drop src_int_vld immediately and discard queued events.

Configuration
REQ-027 Macro CLIC_INT_SRC_COALESCE_EN SHALL select the queue depth.
- Defined: the counter has full CNT_W width (max 2^CNT_W-1 queued events).
- Undefined: the queue is a single pending bit (max 1); src_evt_cnt upper bits read 0, and any event while the bit is set and not dequeued is dropped with src_evt_ovf set.

Verification
REQ-028 Pulse mode, H=3, L=2, one src_event in IDLE -> src_int_vld high 2 edges later for exactly 3 cycles, low 2 cycles, then IDLE, src_busy=0.
REQ-029 Pulse mode, H=0, L=0, three back-to-back events -> three 1-cycle highs separated by 1-cycle lows; src_evt_cnt peaks at 2 with the macro, and src_evt_ovf=1 without it.
REQ-030 Macro on, CNT_W=4, 16 events while held in HIGH with H=15 -> src_evt_cnt=15, src_evt_ovf=1; src_ovf_clr together with a 17th event -> src_evt_ovf stays 1.
REQ-031 Level mode, src_level toggles 0->1->0 at cycles 5 and 9 -> src_int_vld high during cycles 6-9; src_event pulses have no effect.
REQ-032 Pulse mode mid-HIGH with cnt=3, switch to level with src_level=0 -> src_int_vld=0 and cnt=0 after 1 edge; cpurst_b asserted mid-GAP -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pa_clic_int_src.sv
// ---------------------------------------------------------------------------
// pa_clic_int_src
//
// Conditions one peripheral interrupt request before it reaches a CLIC kid
// interrupt-valid input.
//
//   Level mode (src_mode = 0): src_int_vld is src_level delayed by one
//   register stage. The pulse state machine is parked in IDLE and the event
//   queue is held empty.
//
//   Pulse mode (src_mode = 1): every src_event strobe is queued. Each queued
//   event is replayed as a HIGH phase of max(cfg_high_cyc,1) cycles. The
//   HIGH phase is followed by a GAP phase of max(cfg_low_cyc,1) cycles.
//   src_int_vld is high only during HIGH. An event that finds the queue full
//   is dropped and sets the sticky src_evt_ovf flag.
//
// Configuration macro: CLIC_INT_SRC_COALESCE_EN
//   defined   - the queue is a full CNT_W-bit counter (up to 2^CNT_W-1 events)
//   undefined - the queue is a single pending bit. src_evt_cnt reads 0 or 1.
//
// Ports
//   kid_sample_clk  in   block clock, rising edge
//   cpurst_b        in   asynchronous active-low reset
//   src_mode        in   0 = level mode, 1 = pulse mode
//   src_level       in   level request (level mode)
//   src_event       in   one-cycle event strobe (pulse mode)
//   cfg_high_cyc    in   [3:0] pulse-high width, sampled on entry to HIGH
//   cfg_low_cyc     in   [3:0] minimum low gap, sampled on entry to GAP
//   src_ovf_clr     in   clears src_evt_ovf (a same-cycle drop wins)
//   src_int_vld     out  registered interrupt valid
//   src_evt_cnt     out  [CNT_W-1:0] queued events not yet emitted
//   src_evt_ovf     out  sticky "event dropped" flag
//   src_busy        out  state machine not IDLE or queue not empty
// ---------------------------------------------------------------------------
module pa_clic_int_src #(
    parameter int CNT_W = 4
) (
    input  logic             kid_sample_clk,
    input  logic             cpurst_b,
    input  logic             src_mode,
    input  logic             src_level,
    input  logic             src_event,
    input  logic [3:0]       cfg_high_cyc,
    input  logic [3:0]       cfg_low_cyc,
    input  logic             src_ovf_clr,
    output logic             src_int_vld,
    output logic [CNT_W-1:0] src_evt_cnt,
    output logic             src_evt_ovf,
    output logic             src_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Largest value the queue may hold before further events are dropped.
`ifdef CLIC_INT_SRC_COALESCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`else
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1);
`endif

    state_t           state_q, state_d;
    logic [3:0]       timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic             vld_q,   vld_d;

    logic             evt_inc;
    logic             evt_deq;
    logic             evt_drop;
    logic [3:0]       high_len_m1;
    logic [3:0]       low_len_m1;

    // The timer holds the number of cycles remaining after the current one.
    // A zero width is treated as one cycle, so zero maps to a reload of 0.
    assign high_len_m1 = (cfg_high_cyc == 4'd0) ? 4'd0 : cfg_high_cyc - 4'd1;
    assign low_len_m1  = (cfg_low_cyc  == 4'd0) ? 4'd0 : cfg_low_cyc  - 4'd1;

    // Events are counted only in pulse mode.
    assign evt_inc = src_mode & src_event;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge kid_sample_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
            timer_q <= 4'd0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and phase timer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        evt_deq = 1'b0;

        if (!src_mode) begin
            // Level mode parks the machine. Leaving pulse mode aborts any
            // phase in progress on the next edge.
            state_d = ST_IDLE;
            timer_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q != '0) begin
                        state_d = ST_HIGH;
                        timer_d = high_len_m1;
                        evt_deq = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timer_q == 4'd0) begin
                        state_d = ST_GAP;
                        timer_d = low_len_m1;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (timer_q == 4'd0) begin
                        if (cnt_q != '0) begin
                            // Start the next pulse directly, without passing through IDLE.
                            state_d = ST_HIGH;
                            timer_d = high_len_m1;
                            evt_deq = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event queue, overflow flag and interrupt valid
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        evt_drop = 1'b0;

        if (!src_mode) begin
            cnt_d = '0;
        end else if (evt_inc && !evt_deq) begin
            if (cnt_q == CNT_MAX) begin
                evt_drop = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (evt_deq && !evt_inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // An increment and a dequeue in the same cycle cancel each other.
    end

    always_comb begin
        // If a drop and a clear happen in the same cycle, the drop wins so
        // that the dropped event is not lost from view.
        ovf_d = evt_drop | (ovf_q & ~src_ovf_clr);

        // In pulse mode the flop is loaded from the next state. Its output
        // therefore lines up exactly with the registered state.
        vld_d = src_mode ? (state_d == ST_HIGH) : src_level;
    end

    assign src_int_vld = vld_q;
    assign src_evt_cnt = cnt_q;
    assign src_evt_ovf = ovf_q;
    assign src_busy    = (state_q != ST_IDLE) | (cnt_q != '0);

endmodule

// File: tb/tb_pa_clic_int_src.sv
// ---------------------------------------------------------------------------
// tb_pa_clic_int_src
//
// Directed bench for pa_clic_int_src.
//
// A cycle-level reference model tracks the expected behaviour. It works in
// absolute edge numbers: when the current pulse's high phase ends, when its
// gap ends, and how many events are waiting. The model is compared with the
// DUT outputs on every falling edge. Hand-computed literal expectations at
// key points keep the model honest.
// ---------------------------------------------------------------------------
module tb_pa_clic_int_src;

    localparam int CNT_W = 4;
`ifdef CLIC_INT_SRC_COALESCE_EN
    localparam int QMAX = 15;
`else
    localparam int QMAX = 1;
`endif

    logic             clk          = 1'b0;
    logic             cpurst_b     = 1'b1;
    logic             src_mode     = 1'b0;
    logic             src_level    = 1'b0;
    logic             src_event    = 1'b0;
    logic [3:0]       cfg_high_cyc = 4'd0;
    logic [3:0]       cfg_low_cyc  = 4'd0;
    logic             src_ovf_clr  = 1'b0;
    logic             src_int_vld;
    logic [CNT_W-1:0] src_evt_cnt;
    logic             src_evt_ovf;
    logic             src_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    pa_clic_int_src #(.CNT_W(CNT_W)) dut (
        .kid_sample_clk (clk),
        .cpurst_b       (cpurst_b),
        .src_mode       (src_mode),
        .src_level      (src_level),
        .src_event      (src_event),
        .cfg_high_cyc   (cfg_high_cyc),
        .cfg_low_cyc    (cfg_low_cyc),
        .src_ovf_clr    (src_ovf_clr),
        .src_int_vld    (src_int_vld),
        .src_evt_cnt    (src_evt_cnt),
        .src_evt_ovf    (src_evt_ovf),
        .src_busy       (src_busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. It runs on absolute edge numbers.
    // ------------------------------------------------------------------
    int m_cyc = 0;
    int m_hi_end = 0;
    int m_gap_end = -1;
    int m_q = 0;
    bit m_act = 0;
    bit m_ovf = 0;
    bit m_vld = 0;
    bit m_busy = 0;

    initial begin
        bit inc, deq, drop, start;
        forever begin
            @(posedge clk or negedge cpurst_b);
            if (!cpurst_b) begin
                m_cyc = 0; m_hi_end = 0; m_gap_end = -1; m_q = 0;
                m_act = 0; m_ovf = 0; m_vld = 0;
            end else begin
                m_cyc++;
                inc = src_mode && src_event;
                deq = 0; drop = 0; start = 0;
                if (!src_mode) begin
                    m_act = 0;
                    m_q   = 0;
                    m_vld = src_level;
                end else begin
                    if (!m_act)
                        start = (m_q > 0);
                    else if (m_cyc == m_hi_end)
                        m_gap_end = m_cyc + ((cfg_low_cyc == 0) ? 1 : int'(cfg_low_cyc));
                    else if (m_cyc == m_gap_end) begin
                        if (m_q > 0) start = 1;
                        else m_act = 0;
                    end
                    if (start) begin
                        m_act     = 1;
                        deq       = 1;
                        m_hi_end  = m_cyc + ((cfg_high_cyc == 0) ? 1 : int'(cfg_high_cyc));
                        m_gap_end = -1;
                    end
                    if (inc && !deq) begin
                        if (m_q == QMAX) drop = 1;
                        else m_q++;
                    end else if (deq && !inc) begin
                        m_q--;
                    end
                    m_vld = m_act && (m_cyc < m_hi_end);
                end
                m_ovf = drop || (m_ovf && !src_ovf_clr);
            end
            m_busy = m_act || (m_q > 0);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare of the DUT against the model
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && cpurst_b) begin
                checks++;
                if (src_int_vld !== m_vld || int'(src_evt_cnt) != m_q ||
                    src_evt_ovf !== m_ovf || src_busy !== m_busy) begin
                    failures++;
                    $display("FAIL model_cmp t=%0t got vld=%b cnt=%0d ovf=%b busy=%b want vld=%b cnt=%0d ovf=%b busy=%b",
                             $time, src_int_vld, src_evt_cnt, src_evt_ovf, src_busy,
                             m_vld, m_q, m_ovf, m_busy);
                end
            end
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded run time: a stuck run still reports its result.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        #3 cpurst_b = 1'b0;
        tick(2);
        $display("TXN reset: outputs idle");
        lit("rst_vld",  int'(src_int_vld), 0);
        lit("rst_cnt",  int'(src_evt_cnt), 0);
        lit("rst_ovf",  int'(src_evt_ovf), 0);
        lit("rst_busy", int'(src_busy),    0);
        cpurst_b = 1'b1;
        chk_en   = 1'b1;
        tick(1);

        // A: single event, H=3 L=2; cfg_high changed mid-HIGH is ignored
        $display("TXN A: pulse H=3 L=2 single event");
        src_mode = 1; cfg_high_cyc = 4'd3; cfg_low_cyc = 4'd2; src_event = 1;
        tick(1); src_event = 0;
        lit("A_cnt_e1", int'(src_evt_cnt), 1);
        lit("A_vld_e1", int'(src_int_vld), 0);
        tick(1); lit("A_vld_e2", int'(src_int_vld), 1); cfg_high_cyc = 4'd9;
        tick(1); lit("A_vld_e3", int'(src_int_vld), 1);
        tick(1); lit("A_vld_e4", int'(src_int_vld), 1);
        tick(1); lit("A_vld_e5", int'(src_int_vld), 0);
        tick(1); lit("A_busy_e6", int'(src_busy), 1);
        tick(1); lit("A_busy_e7", int'(src_busy), 0);
        lit("A_vld_e7", int'(src_int_vld), 0);

        // B: H=0 L=0, three back-to-back events
        $display("TXN B: pulse H=0 L=0 three events");
        cfg_high_cyc = 4'd0; cfg_low_cyc = 4'd0; src_event = 1;
        tick(1); lit("B_cnt_e1", int'(src_evt_cnt), 1);
        tick(1); lit("B_vld_e2", int'(src_int_vld), 1);
        tick(1); src_event = 0; lit("B_vld_e3", int'(src_int_vld), 0);
`ifdef CLIC_INT_SRC_COALESCE_EN
        lit("B_cnt_peak", int'(src_evt_cnt), 2);
`else
        lit("B_ovf_e3", int'(src_evt_ovf), 1);
`endif
        tick(1); lit("B_vld_e4", int'(src_int_vld), 1);
        tick(1); lit("B_vld_e5", int'(src_int_vld), 0);
`ifdef CLIC_INT_SRC_COALESCE_EN
        tick(1); lit("B_vld_e6", int'(src_int_vld), 1);
`else
        tick(1); lit("B_vld_e6", int'(src_int_vld), 0);
`endif
        tick(4);
        src_ovf_clr = 1; tick(1); src_ovf_clr = 0;
        lit("B_ovf_clr", int'(src_evt_ovf), 0);

        // C: fill the queue while HIGH with H=15, then overflow; a clear in
        //    the same cycle as a drop must lose to the drop
        $display("TXN C: queue fill and overflow, H=15 L=15");
        cfg_high_cyc = 4'd15; cfg_low_cyc = 4'd15; src_event = 1;
        tick(1); src_event = 0;
        tick(1); lit("C_vld_high", int'(src_int_vld), 1);
        src_event = 1;
        tick(QMAX + 1);
        lit("C_cnt_full", int'(src_evt_cnt), QMAX);
        lit("C_ovf_set",  int'(src_evt_ovf), 1);
        src_ovf_clr = 1;
        tick(1);
        lit("C_ovf_clr_vs_set", int'(src_evt_ovf), 1);
        src_event = 0;
        tick(1);
        lit("C_ovf_cleared", int'(src_evt_ovf), 0);
        src_ovf_clr = 0;
        src_mode = 0; src_level = 0;          // flush via level mode
        tick(1); lit("C_flush_cnt", int'(src_evt_cnt), 0);

        // D: abort from mid-HIGH with a queue of up to 3 events
        $display("TXN D: pulse->level abort mid-HIGH");
        src_mode = 1; cfg_high_cyc = 4'd8; cfg_low_cyc = 4'd2; src_event = 1;
        tick(1); src_event = 0;
        tick(1); src_event = 1;
        tick(3); src_event = 0;
        lit("D_vld_pre", int'(src_int_vld), 1);
        lit("D_cnt_pre", int'(src_evt_cnt), (QMAX >= 3) ? 3 : QMAX);
        src_mode = 0; src_level = 0;
        tick(1);
        lit("D_vld_abort",  int'(src_int_vld), 0);
        lit("D_cnt_abort",  int'(src_evt_cnt), 0);
        lit("D_busy_abort", int'(src_busy),    0);
        lit("D_ovf_kept",   int'(src_evt_ovf), (QMAX == 1) ? 1 : 0);
        src_ovf_clr = 1; tick(1); src_ovf_clr = 0;
        lit("D_ovf_clr_level", int'(src_evt_ovf), 0);

        // E: level mode, level high during cycles 5..8, events ignored
        $display("TXN E: level mode toggle with ignored events");
        for (int i = 0; i < 13; i++) begin
            src_level = (i >= 5 && i < 9);
            src_event = (i % 2 == 1);
            tick(1);
            lit("E_vld", int'(src_int_vld), (i >= 5 && i < 9) ? 1 : 0);
            lit("E_cnt", int'(src_evt_cnt), 0);
        end
        src_event = 0;

        // F: level->pulse switch while the level is high
        $display("TXN F: level->pulse switch");
        src_level = 1; tick(1);
        src_mode = 1; src_event = 1; cfg_high_cyc = 4'd2; cfg_low_cyc = 4'd1;
        tick(1); src_event = 0;
        lit("F_vld_switch", int'(src_int_vld), 0);
        lit("F_cnt_switch", int'(src_evt_cnt), 1);
        tick(8);

        // G: mixed pattern, checked against the model only
        $display("TXN G: mixed pattern of 60 cycles");
        for (int i = 0; i < 60; i++) begin
            src_mode     = !(i >= 40 && i < 44);
            src_event    = (i % 3 == 0) || (i % 5 == 1);
            cfg_high_cyc = 4'(i % 4);
            cfg_low_cyc  = 4'((i * 7) % 5);
            src_ovf_clr  = (i % 11 == 10);
            src_level    = (i % 4 >= 2);
            tick(1);
        end
        src_mode = 1; src_event = 0; src_ovf_clr = 0;
        tick(120);
        lit("G_drained_busy", int'(src_busy), 0);

        // H: asynchronous reset mid-GAP with an event queued
        $display("TXN H: async reset mid-GAP");
        cfg_high_cyc = 4'd1; cfg_low_cyc = 4'd8; src_event = 1;
        tick(1); src_event = 0;
        tick(1); src_event = 1;
        tick(1); src_event = 0;
        lit("H_vld_gap", int'(src_int_vld), 0);
        lit("H_cnt_gap", int'(src_evt_cnt), 1);
        lit("H_busy_gap", int'(src_busy), 1);
        @(posedge clk); #2;
        cpurst_b = 1'b0;
        #1;
        lit("H_rst_vld",  int'(src_int_vld), 0);
        lit("H_rst_cnt",  int'(src_evt_cnt), 0);
        lit("H_rst_ovf",  int'(src_evt_ovf), 0);
        lit("H_rst_busy", int'(src_busy),    0);
        tick(2);
        cpurst_b = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
